// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } booth_state_t;

   localparam int BOOTH_W_DEFAULT = 8;

   // Iteration count: a signed multiplier needs WIDTH steps, while an unsigned one
   // needs WIDTH+1 so that the zero extension bit is also scanned.
   function automatic int booth_iters(input int width, input bit signed_en);
      return signed_en ? width : width + 1;
   endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: add or subtract M on {q0,q_m1},
// then arithmetic right shift of {acc,q,q_m1}.
module booth_step
   import booth_pkg::*;
#(
   parameter int WIDTH = BOOTH_W_DEFAULT
) (
   input  logic [WIDTH+1:0] acc,
   input  logic [WIDTH:0]   q,
   input  logic             q_m1,
   input  logic [WIDTH:0]   m,
   output logic [WIDTH+1:0] acc_next,
   output logic [WIDTH:0]   q_next,
   output logic             q_m1_next
);

   logic [WIDTH+1:0] m_ext;
   logic [WIDTH+1:0] sum;

   assign m_ext = {m[WIDTH], m};

   always_comb begin
      sum = acc;
      case ({q[0], q_m1})
         2'b01:   sum = acc + m_ext;
         2'b10:   sum = acc - m_ext;
         default: sum = acc;
      endcase
   end

   assign acc_next  = {sum[WIDTH+1], sum[WIDTH+1:1]};
   assign q_next    = {sum[0], q[WIDTH:1]};
   assign q_m1_next = q[0];

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential radix-2 Booth multiplier, one iteration per clock.
// Define BOOTH_SIGNED_EN for two's complement operands; unsigned otherwise.
module booth_seq_mul
   import booth_pkg::*;
#(
   parameter int WIDTH = BOOTH_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               busy,
   output logic               valid,
   output logic [2*WIDTH-1:0] Y
);

`ifdef BOOTH_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif
   localparam int N     = booth_iters(WIDTH, SIGNED_EN);
   localparam int CNT_W = $clog2(N + 1);

   booth_state_t     state, state_next;
   logic             start_q;
   logic             accept;
   logic             load, step, finish;
   logic [WIDTH+1:0] acc, acc_n;
   logic [WIDTH:0]   q, q_n;
   logic             q_m1, q_m1_n;
   logic [WIDTH:0]   m;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   a_ext, b_ext;
   logic [2*WIDTH-1:0] y_next;

   // Handshake: a launch is the rising edge of start seen while not busy; edges
   // during RUN (including the final iteration) are dropped, never queued.
   assign busy   = (state == RUN);
   assign accept = start & ~start_q & ~busy;

`ifdef BOOTH_SIGNED_EN
   assign a_ext  = {A[WIDTH-1], A};
   assign b_ext  = {B[WIDTH-1], B};
   // After WIDTH steps the product sits in acc and the top WIDTH bits of q.
   assign y_next = {acc_n[WIDTH-1:0], q_n[WIDTH:1]};
`else
   assign a_ext  = {1'b0, A};
   assign b_ext  = {1'b0, B};
   assign y_next = {acc_n[WIDTH-2:0], q_n};
`endif

   booth_step #(.WIDTH(WIDTH)) u_step (
      .acc       (acc),
      .q         (q),
      .q_m1      (q_m1),
      .m         (m),
      .acc_next  (acc_n),
      .q_next    (q_n),
      .q_m1_next (q_m1_n)
   );

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (accept) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == CNT_W'(1)) begin
               finish     = 1'b1;
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         start_q <= 1'b0;
      end else begin
         state   <= state_next;
         start_q <= start;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         q     <= '0;
         q_m1  <= 1'b0;
         m     <= '0;
         cnt   <= '0;
         Y     <= '0;
         valid <= 1'b0;
      end else if (load) begin
         acc   <= '0;
         q     <= b_ext;
         q_m1  <= 1'b0;
         m     <= a_ext;
         cnt   <= CNT_W'(N);
         valid <= 1'b0;
      end else if (step) begin
         acc  <= acc_n;
         q    <= q_n;
         q_m1 <= q_m1_n;
         cnt  <= cnt - CNT_W'(1);
         if (finish) begin
            Y     <= y_next;
            valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed bench for booth_seq_mul; follows BOOTH_SIGNED_EN for the number format.
module tb_booth_seq_mul;

`ifdef BOOTH_SIGNED_EN
   localparam int N = 8;
`else
   localparam int N = 9;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  A, B;
   logic        busy, valid;
   logic [15:0] Y;

   int          tests  = 0;
   int          failed = 0;
   logic [15:0] exp_y  = '0;

   booth_seq_mul #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .valid (valid),
      .Y     (Y)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
`ifdef BOOTH_SIGNED_EN
      return 16'($signed(a) * $signed(b));
`else
      return 16'(a) * 16'(b);
`endif
   endfunction

   // mode 1: toggle start and scramble A/B part-way through RUN.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag, input int mode);
      logic [15:0] exp;
      int lat, busy_cnt;
      exp = ref_mul(a, b);
      @(negedge clk); start = 1'b0; A = a; B = b;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      check({tag, "_valid_at_accept"}, 32'(valid), 32'd0);
      check({tag, "_y_held_at_accept"}, 32'(Y), 32'(exp_y));
      busy_cnt = busy ? 1 : 0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         if (mode == 1 && i == 3) begin
            @(negedge clk); start = 1'b0;
            A = 8'($urandom_range(0, 255)); B = 8'($urandom_range(0, 255));
         end
         if (mode == 1 && i == 4) begin
            @(negedge clk); start = 1'b1;
         end
         @(posedge clk); #1;
         if (valid) begin
            lat = i;
            break;
         end
         if (busy) busy_cnt++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(N));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(N));
      check({tag, "_y"}, 32'(Y), 32'(exp));
      exp_y = exp;
   endtask

   initial begin
      logic [7:0] ra, rb;
      rst = 1'b1; start = 1'b0; A = '0; B = '0;
      repeat (2) @(negedge clk);
      check("reset_y", 32'(Y), 32'd0);
      check("reset_valid", 32'(valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      @(negedge clk); rst = 1'b0;

      // Directed vectors; hand-computed products for each number format.
`ifdef BOOTH_SIGNED_EN
      run_op(8'd3,   8'd5,   "s_3x5", 0);     check("s_3x5_const",   32'(exp_y), 32'h000F);
      run_op(8'hFD,  8'd5,   "s_m3x5", 0);    check("s_m3x5_const",  32'(exp_y), 32'hFFF1);
      run_op(8'h80,  8'h80,  "s_min2", 0);    check("s_min2_const",  32'(Y),     32'h4000);
      run_op(8'hFF,  8'hFF,  "s_m1xm1", 0);   check("s_m1xm1_const", 32'(Y),     32'h0001);
`else
      run_op(8'd3,   8'd5,   "u_3x5", 0);     check("u_3x5_const",   32'(Y), 32'h000F);
      run_op(8'hFD,  8'd5,   "u_253x5", 0);   check("u_253x5_const", 32'(Y), 32'h04F1);
      run_op(8'h80,  8'h80,  "u_128sq", 0);   check("u_128sq_const", 32'(Y), 32'h4000);
      run_op(8'hFF,  8'hFF,  "u_255sq", 0);   check("u_255sq_const", 32'(Y), 32'hFE01);
`endif

      // Start still held high: no relaunch, result stays put.
      repeat (5) @(negedge clk);
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_busy", 32'(busy), 32'd0);
      check("hold_y", 32'(Y), 32'(exp_y));

      // Relaunch from DONE; run_op checks valid drops and Y holds at accept.
      run_op(8'd7, 8'd9, "relaunch", 0);

      // Mid-run start toggle and operand change must be ignored.
      for (int k = 0; k < 3; k++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run_op(ra, rb, $sformatf("midrun%0d", k), 1);
      end

      // Reset at cycle 4 of RUN discards everything immediately.
      @(negedge clk); start = 1'b0; A = 8'd100; B = 8'd77;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #1 check("midrst_busy_before", 32'(busy), 32'd1);
      @(negedge clk); rst = 1'b1; start = 1'b0;
      #1;
      check("midrst_y", 32'(Y), 32'd0);
      check("midrst_valid", 32'(valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      exp_y = '0;
      @(negedge clk); rst = 1'b0;
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "after_rst", 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
